// File: rtl/ivhd_wishbone_master_pkg.sv
// ----------------------------------------------------------------------------
// ivhd_wb_pkg
// Shared types for the single-outstanding Wishbone B4 pipelined master:
//   - t_ivhd_state    : master FSM states
//   - t_wb_master_out : Wishbone control bits driven by the master
//   - t_wb_master_in  : Wishbone termination/flow-control bits seen by it
//   - default address/data widths
//   - helpers classifying a bus termination
// ----------------------------------------------------------------------------
package ivhd_wb_pkg;

    localparam int c_addr_width_default = 32;
    localparam int c_data_width_default = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } t_ivhd_state;

    typedef struct packed {
        logic cyc;
        logic stb;
        logic we;
    } t_wb_master_out;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
        logic stall;
    } t_wb_master_in;

    // Any termination of the current cycle.
    function automatic logic f_rsp_seen(input t_wb_master_in i_in);
        return i_in.ack | i_in.err | i_in.rty;
    endfunction

    // Terminations reported as an error; err/rty win over a simultaneous ack.
    function automatic logic f_rsp_fail(input t_wb_master_in i_in);
        return i_in.err | i_in.rty;
    endfunction

endpackage

// File: rtl/ivhd_wishbone_master_if.sv
// ----------------------------------------------------------------------------
// ivhd_wishbone_master_if
// Bundles the host command/response port and the Wishbone master port.
//   modport master : view of ivhd_wishbone_master
//   modport slave  : view of the host + Wishbone slave driving the master
// Parameters: g_addr_width (byte address bits), g_data_width (data bits).
// ----------------------------------------------------------------------------
interface ivhd_wishbone_master_if
    import ivhd_wb_pkg::*;
#(
    parameter int g_addr_width = c_addr_width_default,
    parameter int g_data_width = c_data_width_default
);
    // Host command / response
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_we_i;
    logic [g_addr_width-1:0]   cmd_addr_i;
    logic [g_data_width-1:0]   cmd_data_i;
    logic [g_data_width/8-1:0] cmd_sel_i;
    logic                      rsp_valid_o;
    logic [g_data_width-1:0]   rsp_data_o;
    logic                      rsp_err_o;
    // Wishbone
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [g_addr_width-1:0]   wb_adr_o;
    logic [g_data_width/8-1:0] wb_sel_o;
    logic [g_data_width-1:0]   wb_dat_o;
    logic                      wb_ack_i;
    logic                      wb_err_i;
    logic                      wb_rty_i;
    logic                      wb_stall_i;
    logic [g_data_width-1:0]   wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

endinterface

// File: rtl/ivhd_wishbone_master_timeout.sv
// ----------------------------------------------------------------------------
// ivhd_wb_timeout
// Cycle counter for the bus-cycle watchdog of ivhd_wishbone_master.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_clear        : restart the count (command accepted)
//   i_en           : count this cycle (master in ISSUE or WAIT)
//   o_expired      : g_timeout_cycles cycles have elapsed while enabled
// ----------------------------------------------------------------------------
module ivhd_wb_timeout #(
    parameter int g_timeout_cycles = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int c_cnt_w = $clog2(g_timeout_cycles + 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Expiry is flagged one cycle early so the FSM leaves exactly
    // g_timeout_cycles edges after the accepting edge.
    assign o_expired = i_en && (r_cnt == c_cnt_w'(g_timeout_cycles - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ivhd_wishbone_master.sv
// ----------------------------------------------------------------------------
// ivhd_wishbone_master
// Single-outstanding Wishbone B4 pipelined master. Converts a valid/ready
// command into one bus cycle and returns status/read data on a one-cycle
// response strobe. All outputs are registered.
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : ivhd_wishbone_master_if.master (command, response, Wishbone)
// Build option: define IVHD_WB_MASTER_TIMEOUT_EN to abort a cycle that gets
// no ack/err/rty within g_timeout_cycles (rsp_err=1, rsp_data=all-ones).
// ----------------------------------------------------------------------------
module ivhd_wishbone_master
    import ivhd_wb_pkg::*;
#(
    parameter int g_addr_width     = c_addr_width_default,
    parameter int g_data_width     = c_data_width_default,
    parameter int g_timeout_cycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    ivhd_wishbone_master_if.master bus
);
    localparam int c_sel_w = g_data_width / 8;

    if (g_timeout_cycles < 1) begin : g_bad_timeout
        $error("g_timeout_cycles must be at least 1");
    end

    t_ivhd_state             r_state,     w_state_nxt;
    t_wb_master_out          r_ctl,       w_ctl_nxt;
    logic [g_addr_width-1:0] r_adr,       w_adr_nxt;
    logic [g_data_width-1:0] r_dat,       w_dat_nxt;
    logic [c_sel_w-1:0]      r_sel,       w_sel_nxt;
    logic                    r_cmd_ready, w_cmd_ready_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic                    r_rsp_err,   w_rsp_err_nxt;
    logic [g_data_width-1:0] r_rsp_data,  w_rsp_data_nxt;

    t_wb_master_in w_in;
    logic          w_accept;
    logic          w_finish;
    logic          w_busy;
    logic          w_timeout;

    assign w_in     = '{ack: bus.wb_ack_i, err: bus.wb_err_i,
                        rty: bus.wb_rty_i, stall: bus.wb_stall_i};
    assign w_accept = bus.cmd_valid_i && r_cmd_ready;
    assign w_busy   = (r_state == S_ISSUE) || (r_state == S_WAIT);

`ifdef IVHD_WB_MASTER_TIMEOUT_EN
    ivhd_wb_timeout #(
        .g_timeout_cycles(g_timeout_cycles)
    ) u_timeout (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_clear  (w_accept),
        .i_en     (w_busy),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_ctl       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctl       <= w_ctl_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_sel       <= w_sel_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ctl_nxt      = r_ctl;
        w_adr_nxt      = r_adr;
        w_dat_nxt      = r_dat;
        w_sel_nxt      = r_sel;
        w_rsp_err_nxt  = r_rsp_err;
        w_rsp_data_nxt = r_rsp_data;
        w_finish       = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                // r_cmd_ready is still low in the first IDLE cycle after reset
                if (w_accept) begin
                    w_state_nxt   = S_ISSUE;
                    w_ctl_nxt.cyc = 1'b1;
                    w_ctl_nxt.stb = 1'b1;
                    w_ctl_nxt.we  = bus.cmd_we_i;
                    w_adr_nxt     = bus.cmd_addr_i;
                    w_dat_nxt     = bus.cmd_data_i;
                    w_sel_nxt     = bus.cmd_sel_i;
                end
            end
            S_ISSUE: begin
                // A slave may terminate in the same edge it takes the strobe.
                if (!w_in.stall) begin
                    w_state_nxt   = S_WAIT;
                    w_ctl_nxt.stb = 1'b0;
                    w_finish      = f_rsp_seen(w_in);
                end
            end
            S_WAIT: begin
                w_finish = f_rsp_seen(w_in);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_finish) begin
            w_state_nxt   = S_DONE;
            w_ctl_nxt.cyc = 1'b0;
            w_ctl_nxt.stb = 1'b0;
            if (f_rsp_fail(w_in)) begin
                w_rsp_err_nxt  = 1'b1;
                w_rsp_data_nxt = '0;
            end else begin
                w_rsp_err_nxt = 1'b0;
                if (!r_ctl.we) begin
                    w_rsp_data_nxt = bus.wb_dat_i;
                end
            end
        end else if (w_timeout) begin
            w_state_nxt    = S_DONE;
            w_ctl_nxt.cyc  = 1'b0;
            w_ctl_nxt.stb  = 1'b0;
            w_rsp_err_nxt  = 1'b1;
            w_rsp_data_nxt = '1;
        end

        w_rsp_valid_nxt = (w_state_nxt == S_DONE);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.wb_cyc_o    = r_ctl.cyc;
    assign bus.wb_stb_o    = r_ctl.stb;
    assign bus.wb_we_o     = r_ctl.we;
    assign bus.wb_adr_o    = r_adr;
    assign bus.wb_dat_o    = r_dat;
    assign bus.wb_sel_o    = r_sel;

endmodule

// File: tb/tb_ivhd_wishbone_master.sv
// ----------------------------------------------------------------------------
// tb_ivhd_wishbone_master
// Self-checking bench for ivhd_wishbone_master. Each transaction is described
// by its command, number of stall cycles, number of cycles the slave waits
// before answering and the kind of answer; expected latency, response flag
// and response data follow from those with simple arithmetic.
// ----------------------------------------------------------------------------
module tb_ivhd_wishbone_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    // answer kinds
    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_RTY    = 2;
    localparam int K_ACKERR = 3;
    localparam int K_NONE   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_rsp_data = 32'h0;

    ivhd_wishbone_master_if #(.g_addr_width(AW), .g_data_width(DW)) bus ();

    ivhd_wishbone_master #(
        .g_addr_width    (AW),
        .g_data_width    (DW),
        .g_timeout_cycles(TO)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        bus.wb_rty_i   = 1'b0;
        bus.wb_stall_i = 1'b0;
        bus.wb_dat_i   = $urandom;
    endtask

    // Called at a negedge. Returns at the DONE-cycle negedge when b2b=1,
    // otherwise one cycle later back in idle.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int nstall, input int nwait,
                           input int kind, input bit b2b);
        logic [31:0] rdat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          k;
        int          w;
        int          stb_cyc;
        bit          got;
        bit          adr_ok;

        rdat = $urandom;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = adr;
        bus.cmd_data_i  = wdat;
        bus.cmd_sel_i   = sel;
        w = 0;
        while (bus.cmd_ready_o !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val("cmd_ready_before_accept", bus.cmd_ready_o, 1'b1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = ~we;
        bus.cmd_addr_i  = $urandom;
        bus.cmd_data_i  = $urandom;
        bus.cmd_sel_i   = ~sel;
        check_val("issue_cyc", bus.wb_cyc_o, 1'b1);
        check_val("issue_stb", bus.wb_stb_o, 1'b1);
        check_val("issue_we", bus.wb_we_o, we);
        check_val("issue_adr", bus.wb_adr_o, adr);
        check_val("issue_dat", bus.wb_dat_o, wdat);
        check_val("issue_sel", bus.wb_sel_o, sel);
        check_val("issue_rsp_valid", bus.rsp_valid_o, 1'b0);

        got = 1'b0; adr_ok = 1'b1; stb_cyc = 0; k = 0;
        while (!got && k < 100) begin
            k++;
            if (bus.wb_stb_o === 1'b1) begin
                stb_cyc++;
                if (bus.wb_adr_o !== adr || bus.wb_dat_o !== wdat || bus.wb_sel_o !== sel)
                    adr_ok = 1'b0;
            end
            bus.wb_stall_i = (k <= nstall);
            if (kind != K_NONE && k == 1 + nstall + nwait) begin
                bus.wb_dat_i = rdat;
                bus.wb_ack_i = (kind == K_ACK) || (kind == K_ACKERR);
                bus.wb_err_i = (kind == K_ERR) || (kind == K_ACKERR);
                bus.wb_rty_i = (kind == K_RTY);
            end
            @(negedge clk);
            clear_slave();
            if (bus.rsp_valid_o === 1'b1) got = 1'b1;
        end

        case (kind)
            K_ACK: begin
                exp_err  = 1'b0;
                exp_data = we ? m_rsp_data : rdat;
                exp_lat  = 1 + nstall + nwait;
            end
            K_NONE: begin
                exp_err  = 1'b1;
                exp_data = 32'hFFFF_FFFF;
                exp_lat  = TO;
            end
            default: begin
                exp_err  = 1'b1;
                exp_data = 32'h0;
                exp_lat  = 1 + nstall + nwait;
            end
        endcase
        m_rsp_data = exp_data;

        check_val("rsp_seen", got, 1'b1);
        check_val("rsp_latency", k, exp_lat);
        check_val("rsp_err", bus.rsp_err_o, exp_err);
        check_val("rsp_data", bus.rsp_data_o, exp_data);
        check_val("stb_cycles", stb_cyc, nstall + 1);
        check_val("stb_payload_stable", adr_ok, 1'b1);
        check_val("done_cyc", bus.wb_cyc_o, 1'b0);
        check_val("done_stb", bus.wb_stb_o, 1'b0);
        check_val("done_cmd_ready", bus.cmd_ready_o, 1'b1);

        if (!b2b) begin
            @(negedge clk);
            check_val("idle_rsp_valid", bus.rsp_valid_o, 1'b0);
            check_val("idle_cmd_ready", bus.cmd_ready_o, 1'b1);
            check_val("idle_cyc", bus.wb_cyc_o, 1'b0);
            check_val("idle_rsp_data_held", bus.rsp_data_o, exp_data);
        end
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        bus.cmd_sel_i   = '0;
        clear_slave();

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        check_val("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check_val("rst_rsp_err", bus.rsp_err_o, 1'b0);
        check_val("rst_rsp_data", bus.rsp_data_o, 32'h0);
        check_val("rst_wb_ctl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 3'b000);
        check_val("rst_wb_adr", bus.wb_adr_o, 32'h0);
        check_val("rst_wb_dat", bus.wb_dat_o, 32'h0);
        check_val("rst_wb_sel", bus.wb_sel_o, 4'h0);
        rst_n = 1'b1;
        #1;
        check_val("rel_cmd_ready_low", bus.cmd_ready_o, 1'b0);
        @(negedge clk);
        check_val("rel_cmd_ready_high", bus.cmd_ready_o, 1'b1);

        // directed cases
        run_txn(1'b1, 32'h0002_C000, 32'hCAFE_BABE, 4'hF, 0, 1, K_ACK, 1'b0);
        run_txn(1'b0, 32'h0002_C004, 32'h0, 4'hF, 3, 1, K_ACK, 1'b0);
        run_txn(1'b0, 32'h0002_C008, 32'h0, 4'hF, 0, 2, K_ERR, 1'b0);
        run_txn(1'b0, 32'h0002_C00C, 32'h0, 4'h3, 1, 0, K_ACK, 1'b0);
        run_txn(1'b0, 32'h0002_C010, 32'h0, 4'hF, 0, 1, K_ACKERR, 1'b0);
        run_txn(1'b1, 32'h0000_0010, 32'h1111_2222, 4'hC, 0, 1, K_ACK, 1'b1);
        run_txn(1'b0, 32'h0000_0014, 32'h0, 4'hF, 0, 1, K_ACK, 1'b0);
`ifdef IVHD_WB_MASTER_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 0, K_NONE, 1'b0);
`else
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 40, K_ACK, 1'b0);
`endif

        // stray terminations outside a cycle are ignored
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        @(negedge clk);
        clear_slave();
        check_val("stray_rsp_valid", bus.rsp_valid_o, 1'b0);
        check_val("stray_cyc", bus.wb_cyc_o, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int r;
            int kind;
            bit b2b;
            r    = $urandom_range(0, 7);
            kind = (r < 5) ? K_ACK : (r - 4);
            b2b  = $urandom_range(0, 1);
            run_txn($urandom_range(0, 1), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), kind, b2b);
            if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);

        // reset in the middle of a cycle
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_addr_i  = 32'h0000_0200;
        bus.cmd_sel_i   = 4'hF;
        while (bus.cmd_ready_o !== 1'b1) @(negedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        check_val("pre_rst_cyc", bus.wb_cyc_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_cyc", bus.wb_cyc_o, 1'b0);
        check_val("mid_rst_stb", bus.wb_stb_o, 1'b0);
        check_val("mid_rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check_val("mid_rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        check_val("mid_rst_rsp_data", bus.rsp_data_o, 32'h0);
        @(negedge clk);
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        clear_slave();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        check_val("post_rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check_val("post_rst_cyc", bus.wb_cyc_o, 1'b0);
        m_rsp_data = 32'h0;
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 1, K_ACK, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ivhd_wishbone_master.md
# ivhd_wishbone_master

Synthesizable single-outstanding Wishbone B4 pipelined master that converts a simple valid/ready command port into bus cycles and returns read data and status on a one-cycle response strobe. It sits between a host-side access engine (register/CSR driver, firmware loader) and the system interconnect, on the system clock domain, replacing the bypassed VME core path when the board is built for simulation.

## Interface
Parameters:
- g_addr_width, 32, address width in bits; byte address, passed unchanged to wb_adr_o
- g_data_width, 32, data width in bits; sel width is g_data_width/8
- g_timeout_cycles, 1024, cycles allowed from strobe assertion to ack/err (timeout build only)

Ports:
- clk_i  in  1  system clock; single clock domain
- rst_n_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  master idle, command accepted when valid&ready at rising edge
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  g_addr_width  byte address
- cmd_data_i  in  g_data_width  write data
- cmd_sel_i  in  g_data_width/8  byte enables
- rsp_valid_o  out  1  one-cycle pulse, transaction finished
- rsp_data_o  out  g_data_width  read data; held until next response
- rsp_err_o  out  1  error/retry/timeout flag, qualified by rsp_valid_o
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control
- wb_adr_o  out  g_addr_width; wb_sel_o  out  g_data_width/8; wb_dat_o  out  g_data_width
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each
- wb_dat_i  in  g_data_width

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: cmd_ready_o=1. On accept, register we/addr/data/sel into wb_* and go to ISSUE with cyc=stb=1.
- ISSUE: stb held with constant adr/dat/sel/we while wb_stall_i=1. At edge with stall=0, stb←0 and go to WAIT, unless ack/err/rty is also sampled at that edge, which goes directly to DONE.
- WAIT: cyc=1, stb=0. ack → DONE with rsp_data←wb_dat_i (reads only; writes leave rsp_data unchanged), rsp_err←0. err or rty → DONE with rsp_err←1, rsp_data←0. ack and err together: err wins.
- DONE: lasts one cycle. cyc=0, rsp_valid_o=1, cmd_ready_o=1. A command accepted in this cycle starts a new transaction; state returns to IDLE otherwise.
- ack/err/rty sampled while cyc=0 is ignored.
- Reset mid-transaction: all outputs return to reset values immediately; cycle abandoned; no response issued.
- Reset values: cmd_ready_o=0 (becomes 1 at the first edge after release), rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, all wb_* outputs 0.

## Timing
- All outputs are registered.
- Zero-wait slave (no stall, ack one cycle after stb): accept at edge N, stb high N..N+1, ack sampled N+2, rsp_valid and cmd_ready high in cycle N+2..N+3. Throughput is one transaction per 3 cycles.
- Each stall cycle adds one cycle. Each ack-wait cycle adds one cycle.

## Configuration
- IVHD_WB_MASTER_TIMEOUT_EN defined: counter cleared on accept, increments each cycle in ISSUE/WAIT. On reaching g_timeout_cycles with no ack/err/rty: drop cyc/stb, go to DONE with rsp_err=1 and rsp_data=all-ones.
- Undefined: no counter; the master waits indefinitely for ack/err/rty.

## Structure
- Package ivhd_wb_pkg: state enum t_ivhd_state, default width constants, packed structs t_wb_master_out/t_wb_master_in.
- Optional sub-module ivhd_wb_timeout: counter plus expiry flag, instantiated only under the macro.

## Test plan
- Write 0xCAFEBABE to 0x0002C000 with sel=0xF, zero-wait slave -> one cyc/stb with we=1, dat=0xCAFEBABE; rsp_valid 2 cycles after accept, rsp_err=0.
- Read 0x0002C004, slave stalls 3 cycles then acks with 0x12345678 -> stb held 4 cycles with stable adr; rsp_data=0x12345678, rsp_err=0.
- Read answered by wb_err_i -> rsp_err=1, rsp_data=0, cyc drops in the same cycle as rsp_valid.
- Two back-to-back commands with cmd_valid held -> second accepted in the DONE cycle of the first; no overlapping cyc.
- Macro defined, g_timeout_cycles=16, slave never acks -> abort 16 cycles after accept, rsp_err=1, rsp_data=0xFFFFFFFF.
- rst_n_i asserted during WAIT -> cyc/stb/rsp_valid 0 immediately; cmd_ready 1 at the first edge after release.
